plc_timer_bank: RTL and testbench

Multi-channel PLC timer bank for the lathe retrofit controller. It is the parametrised successor to the single on-delay start timer. It provides NUM_CH independent channels, and each channel is configured at run time as TON (on-delay), TOF (off-delay), TP (pulse) or MAN (direct pass-through). All channels share a prescaled time base and a global emergency stop. Channel outputs drive spindle, coolant and feed contactors through the pad wrapper.

---
 rtl/plc_timer_bank.sv | 243 ++++++++++++++++++++++++
 tb/tb_plc_timer_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plc_timer_bank.sv
// plc_timer_bank: NUM_CH independent PLC timers (TON / TOF / TP / MAN).
// All channels count a shared prescaled tick and obey a global estop.
// Each channel has its own mode, preset, elapsed counter and output.
//
// Interface timing: cfg_we is a single-cycle write strobe with no ready/ack
// path. A write is accepted on any enabled clock edge where cfg_we=1 and
// cfg_ch names an existing channel; all other writes are dropped silently.
module plc_timer_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int TICK_DIV   = 1000,
  parameter int DEF_PRESET = 20,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                estop,
  input  logic [NUM_CH-1:0]   ch_in,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_preset,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [CNT_W-1:0]    rd_elapsed,
  output logic [NUM_CH-1:0]   q,
  output logic [NUM_CH-1:0]   busy,
  output logic [2*NUM_CH-1:0] dbg_state
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_TIMING = 2'b10,
    ST_DONE   = 2'b11
  } ch_state_e;

  typedef enum logic [1:0] {
    MODE_TON = 2'b00,
    MODE_TOF = 2'b01,
    MODE_TP  = 2'b10,
    MODE_MAN = 2'b11
  } mode_e;

  logic [PS_W-1:0]  ps_q;
  logic             tick;

  ch_state_e        state_q   [NUM_CH];
  ch_state_e        state_d   [NUM_CH];
  mode_e            mode_q    [NUM_CH];
  mode_e            mode_d    [NUM_CH];
  logic [CNT_W-1:0] preset_q  [NUM_CH];
  logic [CNT_W-1:0] preset_d  [NUM_CH];
  logic [CNT_W-1:0] elapsed_q [NUM_CH];
  logic [CNT_W-1:0] elapsed_d [NUM_CH];
  logic [NUM_CH-1:0] q_q, q_d;
  logic [NUM_CH-1:0] in_d_q;
  logic [CNT_W-1:0]  rd_d;

  // Tick is high during the last cycle of each prescaler period.
  always_comb begin
    tick = (ps_q == PS_MAX);
  end

  // Per-channel next state; estop and a config write both override the timer.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      mode_d[i]    = mode_q[i];
      preset_d[i]  = preset_q[i];
      elapsed_d[i] = elapsed_q[i];
      q_d[i]       = q_q[i];

      // Configuration lands even while estop is held.
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        mode_d[i]   = mode_e'(cfg_mode);
        preset_d[i] = cfg_preset;
      end

      if (estop || (cfg_we && (cfg_ch == CH_W'(i)))) begin
        state_d[i]   = ST_IDLE;
        q_d[i]       = 1'b0;
        elapsed_d[i] = '0;
      end else begin
        unique case (mode_q[i])
          MODE_TON: begin
            unique case (state_q[i])
              ST_IDLE: begin
                if (ch_in[i]) begin
                  state_d[i]   = ST_TIMING;
                  elapsed_d[i] = '0;
                end
              end
              ST_TIMING: begin
                if (!ch_in[i]) begin
                  state_d[i]   = ST_IDLE;
                  elapsed_d[i] = '0;
                end else if (elapsed_q[i] == preset_q[i]) begin
                  state_d[i] = ST_DONE;
                  q_d[i]     = 1'b1;
                end else if (tick) begin
                  elapsed_d[i] = elapsed_q[i] + 1'b1;
                end
              end
              ST_DONE: begin
                if (!ch_in[i]) begin
                  state_d[i]   = ST_IDLE;
                  q_d[i]       = 1'b0;
                  elapsed_d[i] = '0;
                end
              end
              default: begin
                state_d[i]   = ST_IDLE;
                q_d[i]       = 1'b0;
                elapsed_d[i] = '0;
              end
            endcase
          end
          MODE_TOF: begin
            unique case (state_q[i])
              ST_IDLE: begin
                if (ch_in[i]) begin
                  state_d[i] = ST_ACTIVE;
                  q_d[i]     = 1'b1;
                end
              end
              ST_ACTIVE: begin
                if (!ch_in[i]) begin
                  state_d[i]   = ST_TIMING;
                  elapsed_d[i] = '0;
                end
              end
              ST_TIMING: begin
                // Retrigger wins over completion so a returning input keeps q high.
                if (ch_in[i]) begin
                  state_d[i]   = ST_ACTIVE;
                  elapsed_d[i] = '0;
                end else if (elapsed_q[i] == preset_q[i]) begin
                  state_d[i] = ST_IDLE;
                  q_d[i]     = 1'b0;
                end else if (tick) begin
                  elapsed_d[i] = elapsed_q[i] + 1'b1;
                end
              end
              default: begin
                state_d[i]   = ST_IDLE;
                q_d[i]       = 1'b0;
                elapsed_d[i] = '0;
              end
            endcase
          end
          MODE_TP: begin
            unique case (state_q[i])
              ST_IDLE: begin
                if (ch_in[i] && !in_d_q[i]) begin
                  state_d[i]   = ST_TIMING;
                  q_d[i]       = 1'b1;
                  elapsed_d[i] = '0;
                end
              end
              ST_TIMING: begin
                // Input is ignored here: the pulse is not retriggerable.
                if (elapsed_q[i] == preset_q[i]) begin
                  state_d[i] = ST_DONE;
                  q_d[i]     = 1'b0;
                end else if (tick) begin
                  elapsed_d[i] = elapsed_q[i] + 1'b1;
                end
              end
              ST_DONE: begin
                if (!ch_in[i]) begin
                  state_d[i]   = ST_IDLE;
                  elapsed_d[i] = '0;
                end
              end
              default: begin
                state_d[i]   = ST_IDLE;
                q_d[i]       = 1'b0;
                elapsed_d[i] = '0;
              end
            endcase
          end
          MODE_MAN: begin
            state_d[i]   = ST_IDLE;
            q_d[i]       = ch_in[i];
            elapsed_d[i] = '0;
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Readback mux; a select beyond the last channel matches nothing and reads 0.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_d = elapsed_q[i];
      end
    end
  end

  // State registers; ena low freezes everything including the prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q       <= '0;
      q_q        <= '0;
      in_d_q     <= '0;
      rd_elapsed <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= ST_IDLE;
        mode_q[i]    <= MODE_TON;
        preset_q[i]  <= CNT_W'(DEF_PRESET);
        elapsed_q[i] <= '0;
      end
    end else if (ena) begin
      ps_q       <= tick ? '0 : ps_q + 1'b1;
      q_q        <= q_d;
      in_d_q     <= ch_in;
      rd_elapsed <= rd_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      preset_q   <= preset_d;
      elapsed_q  <= elapsed_d;
    end
  end

  // Status outputs derived directly from the channel registers.
  always_comb begin
    q = q_q;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]            = (state_q[i] == ST_TIMING);
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: tb/tb_plc_timer_bank.sv
// Directed bench for plc_timer_bank: one instance with a tick every cycle,
// one with a 4-cycle tick and three channels for prescaler/readback checks.
module tb_plc_timer_bank;

  localparam logic [1:0] M_TON = 2'b00;
  localparam logic [1:0] M_TOF = 2'b01;
  localparam logic [1:0] M_TP  = 2'b10;
  localparam logic [1:0] M_MAN = 2'b11;

  logic        clk, reset, ena, estop;
  logic [3:0]  ch_in;
  logic        cfg_we;
  logic [1:0]  cfg_ch, cfg_mode, rd_ch;
  logic [15:0] cfg_preset;

  logic [15:0] rd_a, rd_b;
  logic [3:0]  q_a, busy_a;
  logic [7:0]  dbg_a;
  logic [2:0]  q_b, busy_b;
  logic [5:0]  dbg_b;

  int n_cmp = 0;
  int n_err = 0;

  plc_timer_bank #(.NUM_CH(4), .CNT_W(16), .TICK_DIV(1), .DEF_PRESET(20)) dut_a (
    .clk(clk), .reset(reset), .ena(ena), .estop(estop), .ch_in(ch_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_preset(cfg_preset),
    .rd_ch(rd_ch), .rd_elapsed(rd_a), .q(q_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  plc_timer_bank #(.NUM_CH(3), .CNT_W(16), .TICK_DIV(4), .DEF_PRESET(20)) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .estop(estop), .ch_in(ch_in[2:0]),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_preset(cfg_preset),
    .rd_ch(rd_ch), .rd_elapsed(rd_b), .q(q_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] preset);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_preset = preset;
    step;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ena = 1'b1; estop = 1'b0; ch_in = '0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_preset = '0; rd_ch = '0;
    step; step;
    n_cmp++; if ({q_a, busy_a} !== 8'h00) begin n_err++; $display("FAIL reset_a_out: got %h exp 00", {q_a, busy_a}); end
    n_cmp++; if (rd_a !== 16'd0) begin n_err++; $display("FAIL reset_a_rd: got %0d exp 0", rd_a); end
    n_cmp++; if (dbg_a !== 8'h00) begin n_err++; $display("FAIL reset_a_state: got %h exp 00", dbg_a); end
    n_cmp++; if ({q_b, busy_b, rd_b} !== 22'd0) begin n_err++; $display("FAIL reset_b_out: got %h exp 0", {q_b, busy_b, rd_b}); end
    reset = 1'b0;
  endtask

  // Must run straight after reset release so the prescaler phase is known.
  task automatic test_prescaler;
    cfg_write(2'd0, M_TON, 16'd2);            // edge 1
    ch_in = 4'b0001;
    step;                                     // edge 2: TIMING
    step;                                     // edge 3
    n_cmp++; if (busy_b[0] !== 1'b1) begin n_err++; $display("FAIL ps_busy: got %b exp 1", busy_b[0]); end
    n_cmp++; if (rd_b !== 16'd0) begin n_err++; $display("FAIL ps_rd_e3: got %0d exp 0", rd_b); end
    step; step;                               // edges 4,5
    n_cmp++; if (rd_b !== 16'd1) begin n_err++; $display("FAIL ps_rd_e5: got %0d exp 1", rd_b); end
    step; step; step;                         // edges 6,7,8
    n_cmp++; if ({q_b[0], rd_b} !== {1'b0, 16'd1}) begin n_err++; $display("FAIL ps_e8: got q=%b rd=%0d exp q=0 rd=1", q_b[0], rd_b); end
    step;                                     // edge 9
    n_cmp++; if ({q_b[0], rd_b} !== {1'b1, 16'd2}) begin n_err++; $display("FAIL ps_e9: got q=%b rd=%0d exp q=1 rd=2", q_b[0], rd_b); end
    rd_ch = 2'd3;
    step;
    n_cmp++; if (rd_b !== 16'd0) begin n_err++; $display("FAIL ps_rd_oor: got %0d exp 0", rd_b); end
    rd_ch = 2'd0;
    step;
    n_cmp++; if (rd_b !== 16'd2) begin n_err++; $display("FAIL ps_rd_back: got %0d exp 2", rd_b); end
    ch_in = '0;
    step;
  endtask

  task automatic test_ton;
    ch_in = '0;
    cfg_write(2'd0, M_TON, 16'd5);
    rd_ch = 2'd0;
    ch_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      step;
      n_cmp++; if ({busy_a[0], q_a[0]} !== 2'b10) begin n_err++; $display("FAIL ton_timing_e%0d: got busy,q=%b exp 10", k, {busy_a[0], q_a[0]}); end
      if (k == 4) begin
        n_cmp++; if (rd_a !== 16'd2) begin n_err++; $display("FAIL ton_rd_e4: got %0d exp 2", rd_a); end
      end
    end
    step;                                     // edge 7
    n_cmp++; if ({busy_a[0], q_a[0], rd_a} !== {2'b01, 16'd5}) begin n_err++; $display("FAIL ton_done: got busy=%b q=%b rd=%0d exp 0 1 5", busy_a[0], q_a[0], rd_a); end
    ch_in = '0;
    step;
    n_cmp++; if (q_a[0] !== 1'b0) begin n_err++; $display("FAIL ton_release: got %b exp 0", q_a[0]); end
    step;
    n_cmp++; if (rd_a !== 16'd0) begin n_err++; $display("FAIL ton_rd_clear: got %0d exp 0", rd_a); end
  endtask

  task automatic test_ton_abort;
    ch_in = 4'b0001;
    step; step; step;
    ch_in = '0;
    step;
    n_cmp++; if (busy_a[0] !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b exp 0", busy_a[0]); end
    for (int k = 0; k < 8; k++) begin
      step;
      n_cmp++; if (q_a[0] !== 1'b0) begin n_err++; $display("FAIL abort_q_%0d: got %b exp 0", k, q_a[0]); end
    end
    n_cmp++; if (rd_a !== 16'd0) begin n_err++; $display("FAIL abort_rd: got %0d exp 0", rd_a); end
  endtask

  task automatic test_ena_hold;
    ch_in = 4'b0001;
    step; step; step;                         // elapsed 0,1,2
    ena = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = M_MAN; cfg_preset = 16'd1;
    step; step; step;
    cfg_we = 1'b0;
    n_cmp++; if ({busy_a[0], rd_a} !== {1'b1, 16'd1}) begin n_err++; $display("FAIL ena_hold: got busy=%b rd=%0d exp 1 1", busy_a[0], rd_a); end
    ena = 1'b1;
    step; step;
    n_cmp++; if ({busy_a[0], q_a[0], rd_a} !== {2'b10, 16'd3}) begin n_err++; $display("FAIL ena_resume: got busy=%b q=%b rd=%0d exp 1 0 3", busy_a[0], q_a[0], rd_a); end
    step; step;
    n_cmp++; if (q_a[0] !== 1'b1) begin n_err++; $display("FAIL ena_done: got %b exp 1", q_a[0]); end
    ch_in = '0;
    step;
  endtask

  task automatic test_tof;
    ch_in = '0;
    cfg_write(2'd1, M_TOF, 16'd4);
    rd_ch = 2'd1;
    ch_in = 4'b0010;
    step;
    n_cmp++; if ({q_a[1], busy_a[1]} !== 2'b10) begin n_err++; $display("FAIL tof_active: got q,busy=%b exp 10", {q_a[1], busy_a[1]}); end
    step;
    ch_in = '0;
    step;
    n_cmp++; if ({q_a[1], busy_a[1]} !== 2'b11) begin n_err++; $display("FAIL tof_timing: got q,busy=%b exp 11", {q_a[1], busy_a[1]}); end
    for (int k = 1; k <= 4; k++) begin
      step;
      n_cmp++; if (q_a[1] !== 1'b1) begin n_err++; $display("FAIL tof_hold_%0d: got %b exp 1", k, q_a[1]); end
    end
    step;
    n_cmp++; if ({q_a[1], busy_a[1]} !== 2'b00) begin n_err++; $display("FAIL tof_expire: got q,busy=%b exp 00", {q_a[1], busy_a[1]}); end
    // Retrigger after two counted ticks
    ch_in = 4'b0010; step;
    ch_in = '0; step; step; step;
    ch_in = 4'b0010; step;
    n_cmp++; if ({q_a[1], busy_a[1], rd_a} !== {2'b10, 16'd2}) begin n_err++; $display("FAIL tof_retrig: got q=%b busy=%b rd=%0d exp 1 0 2", q_a[1], busy_a[1], rd_a); end
    step;
    n_cmp++; if ({q_a[1], rd_a} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL tof_retrig_rd: got q=%b rd=%0d exp 1 0", q_a[1], rd_a); end
    ch_in = '0;
    for (int k = 0; k < 6; k++) step;
    n_cmp++; if (q_a[1] !== 1'b0) begin n_err++; $display("FAIL tof_final: got %b exp 0", q_a[1]); end
  endtask

  task automatic test_tp;
    int hi;
    hi = 0;
    ch_in = '0;
    cfg_write(2'd2, M_TP, 16'd3);
    ch_in = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step;
      if (q_a[2]) hi++;
    end
    n_cmp++; if (hi !== 4) begin n_err++; $display("FAIL tp_width: got %0d exp 4", hi); end
    n_cmp++; if ({q_a[2], busy_a[2]} !== 2'b00) begin n_err++; $display("FAIL tp_held: got q,busy=%b exp 00", {q_a[2], busy_a[2]}); end
    ch_in = '0; step;
    ch_in = 4'b0100; step;
    n_cmp++; if (q_a[2] !== 1'b1) begin n_err++; $display("FAIL tp_second: got %b exp 1", q_a[2]); end
    step; step; step; step;
    n_cmp++; if (q_a[2] !== 1'b0) begin n_err++; $display("FAIL tp_second_end: got %b exp 0", q_a[2]); end
    ch_in = '0; step;
  endtask

  task automatic test_preset_zero;
    ch_in = '0;
    cfg_write(2'd0, M_TON, 16'd0);
    cfg_write(2'd1, M_TOF, 16'd0);
    cfg_write(2'd2, M_TP, 16'd0);
    ch_in = 4'b0001; step;
    n_cmp++; if ({busy_a[0], q_a[0]} !== 2'b10) begin n_err++; $display("FAIL p0_ton_e1: got busy,q=%b exp 10", {busy_a[0], q_a[0]}); end
    step;
    n_cmp++; if (q_a[0] !== 1'b1) begin n_err++; $display("FAIL p0_ton_e2: got %b exp 1", q_a[0]); end
    ch_in = 4'b0100; step;
    n_cmp++; if (q_a[2] !== 1'b1) begin n_err++; $display("FAIL p0_tp_e1: got %b exp 1", q_a[2]); end
    step;
    n_cmp++; if (q_a[2] !== 1'b0) begin n_err++; $display("FAIL p0_tp_e2: got %b exp 0", q_a[2]); end
    ch_in = 4'b0010; step;
    ch_in = '0; step;
    n_cmp++; if ({q_a[1], busy_a[1]} !== 2'b11) begin n_err++; $display("FAIL p0_tof_timing: got q,busy=%b exp 11", {q_a[1], busy_a[1]}); end
    step;
    n_cmp++; if (q_a[1] !== 1'b0) begin n_err++; $display("FAIL p0_tof_drop: got %b exp 0", q_a[1]); end
  endtask

  task automatic test_estop;
    ch_in = '0; step;
    cfg_write(2'd0, M_TON, 16'd10);
    cfg_write(2'd1, M_TOF, 16'd10);
    cfg_write(2'd2, M_TP, 16'd10);
    cfg_write(2'd3, M_TON, 16'd10);
    ch_in = 4'b1111; step;
    ch_in = 4'b1101; step; step;
    n_cmp++; if ({busy_a, q_a} !== 8'b1111_0110) begin n_err++; $display("FAIL estop_pre: got busy=%b q=%b exp 1111 0110", busy_a, q_a); end
    estop = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_mode = M_MAN; cfg_preset = 16'd7;
    step;
    cfg_we = 1'b0;
    n_cmp++; if ({busy_a, q_a} !== 8'h00) begin n_err++; $display("FAIL estop_cut: got busy=%b q=%b exp 0000 0000", busy_a, q_a); end
    step;
    n_cmp++; if (dbg_a !== 8'h00) begin n_err++; $display("FAIL estop_held: got %h exp 00", dbg_a); end
    estop = 1'b0;
    step;                                     // release edge r
    n_cmp++; if ({busy_a, q_a} !== 8'b0001_1000) begin n_err++; $display("FAIL estop_release: got busy=%b q=%b exp 0001 1000", busy_a, q_a); end
    ch_in = 4'b0101; step;                    // r+1
    n_cmp++; if ({busy_a, q_a} !== 8'b0001_0000) begin n_err++; $display("FAIL man_low: got busy=%b q=%b exp 0001 0000", busy_a, q_a); end
    ch_in = 4'b1101; step;                    // r+2
    n_cmp++; if (q_a !== 4'b1000) begin n_err++; $display("FAIL man_high: got %b exp 1000", q_a); end
    for (int k = 3; k <= 10; k++) step;       // r+10
    n_cmp++; if (q_a[0] !== 1'b0) begin n_err++; $display("FAIL estop_preset_early: got %b exp 0", q_a[0]); end
    step;                                     // r+11
    n_cmp++; if (q_a[0] !== 1'b1) begin n_err++; $display("FAIL estop_preset_kept: got %b exp 1", q_a[0]); end
  endtask

  task automatic test_reset_mid_count;
    ch_in = 4'b1111; step;
    ch_in = 4'b1101; step; step;
    n_cmp++; if ({busy_a, q_a} !== 8'b0010_1011) begin n_err++; $display("FAIL rst_pre: got busy=%b q=%b exp 0010 1011", busy_a, q_a); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy_a, q_a, dbg_a} !== 16'h0000) begin n_err++; $display("FAIL rst_async: got busy=%b q=%b st=%h exp 0", busy_a, q_a, dbg_a); end
    n_cmp++; if ({rd_a, rd_b, q_b} !== 35'd0) begin n_err++; $display("FAIL rst_async_rd: got rd_a=%0d rd_b=%0d q_b=%b exp 0", rd_a, rd_b, q_b); end
    step;
    reset = 1'b0;
    ch_in = '0;
    step;
  endtask

  // Sequence and final report
  initial begin
    test_reset;
    test_prescaler;
    test_ton;
    test_ton_abort;
    test_ena_hold;
    test_tof;
    test_tp;
    test_preset_zero;
    test_estop;
    test_reset_mid_count;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
